// File: rtl/mem_pkg.sv
// mem_pkg: shared types, constants and helpers for the MEM-stage data memory.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmem_state_e;

    localparam int BYTE_LANES      = 4;
    localparam int DMEM_ADDR_WIDTH = 12;

    // Word index of a byte address (drops the byte-in-word bits).
    function automatic int unsigned word_idx(input logic [31:0] addr);
        return addr >> 2;
    endfunction

    // Even-parity bit per byte lane: each bit makes its byte plus parity have an even count of ones.
    function automatic logic [BYTE_LANES-1:0] byte_parity(input logic [31:0] data);
        logic [BYTE_LANES-1:0] par;
        for (int b = 0; b < BYTE_LANES; b++) begin
            par[b] = ^data[8*b +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous byte-enable write and asynchronous read.
// With DMEM_PARITY_EN defined, a per-byte even-parity nibble is stored alongside each word
// and par_err reports any mismatch on the currently addressed word.
module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [BYTE_LANES-1:0] be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
`ifdef DMEM_PARITY_EN
    ,
    output logic                  par_err
`endif
);
    localparam int ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ROW_W-1:0] row;
    logic [31:0]      mem [DEPTH];
`ifdef DMEM_PARITY_EN
    logic [BYTE_LANES-1:0] par [DEPTH];
`endif

    assign row = ROW_W'(idx);

    // Byte-lane write of the addressed word.
    // NOTE: storage has no reset on purpose; resetting a memory array forces it into flops.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTE_LANES; b++) begin
                if (be[b]) begin
                    mem[row][8*b +: 8] <= wdata[8*b +: 8];
`ifdef DMEM_PARITY_EN
                    par[row][b]        <= ^wdata[8*b +: 8];
`endif
                end
            end
        end
    end

    // Asynchronous read of the addressed word and its parity check.
    always_comb begin
        rdata = mem[row];
`ifdef DMEM_PARITY_EN
        par_err = |(par[row] ^ byte_parity(mem[row]));
`endif
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the MEM-stage data bus.
// Accepts one load or store at a time, inserts WAIT_STATES cycles before completing,
// pulses ready_o for one cycle and flags rejected requests on err_o.
// Optional feature macro: DMEM_PARITY_EN (per-byte parity stored and checked on loads).
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DMEM_ADDR_WIDTH,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  re_i,
    input  logic                  we_i,
    input  logic [BYTE_LANES-1:0] be_i,
    inout  wire  [31:0]           bus_io,
    output logic                  ready_o,
    output logic                  err_o
);
    localparam int IDX_W = ADDR_WIDTH - 2;

    dmem_state_e           state;
    dmem_state_e           next_state;
    logic [3:0]            wait_cnt;
    logic [IDX_W-1:0]      cap_idx;
    logic [BYTE_LANES-1:0] cap_be;
    logic [31:0]           cap_wdata;
    logic                  cap_load;
    logic                  cap_err;

    logic                  req;
    logic                  req_err;
    logic                  accept;
    logic [31:0]           rd_data;
    logic                  mem_we;
    logic                  bus_drive;
`ifdef DMEM_PARITY_EN
    logic                  par_err;
`endif

    // Request decode and rejection checks on the live request.
    always_comb begin
        req     = re_i | we_i;
        req_err = (re_i & we_i)
                | (addr_i[1:0] != 2'b00)
                | (word_idx(32'(addr_i)) >= DEPTH)
                | (we_i & (be_i == '0));
    end

    assign accept = (state == IDLE) && req;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        ready_o    = 1'b0;
        err_o      = 1'b0;
        mem_we     = 1'b0;
        bus_drive  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = (WAIT_STATES > 0 && !req_err) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
                ready_o    = 1'b1;
`ifdef DMEM_PARITY_EN
                err_o      = cap_err | (cap_load & par_err);
`else
                err_o      = cap_err;
`endif
                mem_we     = !cap_load && !cap_err;
                bus_drive  = cap_load;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture at accept and wait-state countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            cap_idx   <= '0;
            cap_be    <= '0;
            cap_wdata <= '0;
            cap_load  <= 1'b0;
            cap_err   <= 1'b0;
        end else if (accept) begin
            wait_cnt  <= 4'(WAIT_STATES);
            cap_idx   <= addr_i[ADDR_WIDTH-1:2];
            cap_be    <= be_i;
            cap_wdata <= bus_io;
            cap_load  <= re_i & ~we_i;
            cap_err   <= req_err;
        end else if (state == WAIT) begin
            wait_cnt  <= wait_cnt - 4'd1;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .idx     (cap_idx),
        .be      (cap_be),
        .wdata   (cap_wdata),
        .rdata   (rd_data)
`ifdef DMEM_PARITY_EN
        ,
        .par_err (par_err)
`endif
    );

    // Load data only in DONE; a rejected load returns zero, otherwise the bus is released.
    assign bus_io = bus_drive ? (cap_err ? 32'h0 : rd_data) : 'z;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// u_dut0: WAIT_STATES=0, DEPTH=1000 (word index 1000 is out of range).
// u_dut3: WAIT_STATES=3, DEPTH=1024.
module tb_dmem_responder;

    typedef struct {
        string       tag;
        int          lat;
        logic        err;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [11:0] addr0, addr3;
    logic        re0, we0, re3, we3;
    logic [3:0]  be0, be3;
    logic        tb_en0, tb_en3;
    logic [31:0] tb_val0, tb_val3;
    wire  [31:0] bus0, bus3;
    logic        rdy0, err0, rdy3, err3;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    logic [31:0] model [2][1024];

    assign bus0 = tb_en0 ? tb_val0 : 'z;
    assign bus3 = tb_en3 ? tb_val3 : 'z;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(12), .DEPTH(1000), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .addr_i(addr0), .re_i(re0), .we_i(we0),
        .be_i(be0), .bus_io(bus0), .ready_o(rdy0), .err_o(err0)
    );

    dmem_responder #(.ADDR_WIDTH(12), .DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .addr_i(addr3), .re_i(re3), .we_i(we3),
        .be_i(be3), .bus_io(bus3), .ready_o(rdy3), .err_o(err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input bit re, input bit we, input logic [11:0] a,
                         input logic [3:0] be, input bit en, input logic [31:0] v);
        if (d == 0) begin
            re0 = re; we0 = we; addr0 = a; be0 = be; tb_en0 = en; tb_val0 = v;
        end else begin
            re3 = re; we3 = we; addr3 = a; be3 = be; tb_en3 = en; tb_val3 = v;
        end
    endtask

    task automatic set_bus(input int d, input bit en);
        if (d == 0) tb_en0 = en;
        else        tb_en3 = en;
    endtask

    function automatic logic get_rdy(input int d);
        return (d == 0) ? rdy0 : rdy3;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? err0 : err3;
    endfunction

    function automatic logic [31:0] get_bus(input int d);
        return (d == 0) ? bus0 : bus3;
    endfunction

    // One request: predict, push, drive, wait for ready_o, pop and compare.
    task automatic txn(input int d, input string tag, input bit re, input bit we,
                       input logic [11:0] a, input logic [3:0] be, input logic [31:0] wd,
                       input bit exp_perr = 1'b0);
        exp_t e;
        int   m, idx, depth, ws, cnt;
        bit   req_err, is_load, ldrv, got;

        m       = (d == 0) ? 0 : 1;
        depth   = (d == 0) ? 1000 : 1024;
        ws      = (d == 0) ? 0 : 3;
        idx     = int'(a >> 2);
        req_err = (re && we) || (a[1:0] != 2'b00) || (idx >= depth) || (we && be == 4'h0);
        is_load = re && !we;

        e.tag      = tag;
        e.lat      = req_err ? 1 : 1 + ws;
        e.err      = req_err || exp_perr;
        e.chk_data = is_load;
        e.data     = req_err ? 32'h0 : model[m][idx];
        if (!req_err && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[m][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        sb.push_back(e);

        ldrv = is_load && (e.lat > 1);
        @(negedge clk);
        drive(d, re, we, a, be, we || ldrv, we ? wd : 32'h0);

        cnt = 0;
        got = 1'b0;
        while (cnt < 40 && !got) begin
            @(posedge clk);
            #1;
            cnt++;
            if (get_rdy(d)) begin
                got = 1'b1;
            end else if (ldrv) begin
                check({tag, "_bus_released"}, get_bus(d), 32'h0);
                if (cnt == e.lat - 1) begin
                    ldrv = 1'b0;
                    set_bus(d, 1'b0);
                end
            end
        end

        e = sb.pop_front();
        if (!got) begin
            check({e.tag, "_timeout"}, 32'(got), 32'd1);
        end else begin
            check({e.tag, "_lat"}, 32'(cnt), 32'(e.lat));
            check({e.tag, "_err"}, 32'(get_err(d)), 32'(e.err));
            if (e.chk_data) check({e.tag, "_data"}, get_bus(d), e.data);
        end

        @(negedge clk);
        drive(d, 1'b0, 1'b0, 12'h0, 4'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check({tag, "_ready_pulse"}, 32'(get_rdy(d)), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive(0, 1'b0, 1'b0, 12'h0, 4'h0, 1'b1, 32'h0);
        drive(3, 1'b0, 1'b0, 12'h0, 4'h0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_ready0", 32'(rdy0), 32'd0);
        check("rst_err0",   32'(err0), 32'd0);
        check("rst_ready3", 32'(rdy3), 32'd0);
        check("rst_err3",   32'(err3), 32'd0);
        check("rst_bus0",   bus0, 32'h0);
        set_bus(0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero wait states: full store, load, byte-lane merge, last in-range word.
        txn(0, "st_full",   1'b0, 1'b1, 12'h010, 4'b1111, 32'hDEADBEEF);
        txn(0, "ld_full",   1'b1, 1'b0, 12'h010, 4'b0000, 32'h0);
        txn(0, "st_byte0",  1'b0, 1'b1, 12'h010, 4'b0001, 32'h000000AA);
        txn(0, "ld_merge",  1'b1, 1'b0, 12'h010, 4'b0000, 32'h0);
        txn(0, "st_last",   1'b0, 1'b1, 12'hF9C, 4'b1111, 32'h0BADF00D);
        txn(0, "ld_last",   1'b1, 1'b0, 12'hF9C, 4'b0000, 32'h0);

        // Rejected requests: all complete in one cycle and leave memory untouched.
        txn(0, "err_rewe",  1'b1, 1'b1, 12'h010, 4'b1111, 32'hFFFFFFFF);
        txn(0, "err_mis_ld",1'b1, 1'b0, 12'h002, 4'b0000, 32'h0);
        txn(0, "err_oor_ld",1'b1, 1'b0, 12'hFA0, 4'b0000, 32'h0);
        txn(0, "err_oor_st",1'b0, 1'b1, 12'hFA0, 4'b1111, 32'h55555555);
        txn(0, "err_be0",   1'b0, 1'b1, 12'h010, 4'b0000, 32'h12121212);
        txn(0, "ld_after_err", 1'b1, 1'b0, 12'h010, 4'b0000, 32'h0);

        // Three wait states: latency and bus release while waiting.
        txn(3, "w3_st",     1'b0, 1'b1, 12'h020, 4'b1111, 32'h12345678);
        txn(3, "w3_ld",     1'b1, 1'b0, 12'h020, 4'b0000, 32'h0);
        txn(3, "w3_err_mis",1'b1, 1'b0, 12'h022, 4'b0000, 32'h0);
        txn(3, "w3_st_hi",  1'b0, 1'b1, 12'h020, 4'b1100, 32'hABCD0000);
        txn(3, "w3_ld_hi",  1'b1, 1'b0, 12'h020, 4'b0000, 32'h0);
        txn(3, "w3_st_old", 1'b0, 1'b1, 12'h040, 4'b1111, 32'h11111111);

        // Reset during the wait phase of a store: no completion, no write.
        @(negedge clk);
        drive(3, 1'b0, 1'b1, 12'h040, 4'b1111, 1'b1, 32'h22222222);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_mid_pre_ready", 32'(rdy3), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(3, 1'b0, 1'b0, 12'h0, 4'h0, 1'b0, 32'h0);
        #1;
        check("rst_mid_ready", 32'(rdy3), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("rst_mid_no_ready", 32'(rdy3), 32'd0);
        end
        txn(3, "w3_ld_old", 1'b1, 1'b0, 12'h040, 4'b0000, 32'h0);

`ifdef DMEM_PARITY_EN
        // Corrupt one stored bit: data is still returned but flagged.
        txn(0, "par_st",    1'b0, 1'b1, 12'h030, 4'b1111, 32'hCAFEF00D);
        @(negedge clk);
        u_dut0.u_array.mem[12][3] = ~u_dut0.u_array.mem[12][3];
        model[0][12][3] = ~model[0][12][3];
        txn(0, "par_ld_bad",   1'b1, 1'b0, 12'h030, 4'b0000, 32'h0, 1'b1);
        txn(0, "par_ld_clean", 1'b1, 1'b0, 12'h010, 4'b0000, 32'h0);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
